// File: rtl/bf_uart_io_if.sv
// bf_uart_io_if: bfcpu io_* port bundle between the CPU and bf_uart_io.
// Ports: master = CPU (req/dir/wdata out, ack/rdata in); slave = peripheral.
interface bf_uart_io_if;
    logic       io_req;
    logic       io_dir;
    logic [7:0] io_wdata;
    logic       io_ack;
    logic [7:0] io_rdata;

    modport master (
        output io_req, io_dir, io_wdata,
        input  io_ack, io_rdata
    );

    modport slave (
        input  io_req, io_dir, io_wdata,
        output io_ack, io_rdata
    );
endinterface

// File: rtl/bf_uart_io.sv
// bf_uart_io: bfcpu I/O peripheral; '.' sends a byte and ',' receives a
// byte over an 8N1 UART, with 2^FIFO_AW-entry TX and RX FIFOs.
// Ports: clk, rst (sync, active-high), io (bf_uart_io_if.slave:
// io_req/io_dir/io_wdata in, io_ack/io_rdata out), uart_rx in, uart_tx out.
// Option BF_UART_CRLF_EN: a write of 0x0A is sent as 0x0D,0x0A.

`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module bf_uart_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic [AW:0] count
);
    logic [7:0]  mem [2**AW];
    logic [AW:0] wp;
    logic [AW:0] rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wdata;
    end

    // Show-ahead read: the head byte is visible before the pop.
    assign rdata = mem[rp[AW-1:0]];
    assign count = wp - rp;
endmodule

module bf_uart_io #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    bf_uart_io_if.slave io,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef BF_UART_CRLF_EN
    localparam logic [FIFO_AW:0] TWO_FREE =
        (FIFO_AW+1)'(2 ** FIFO_AW - 2);
`endif

    // FIFOs
    logic               tx_push;
    logic [7:0]         tx_wdata;
    logic               tx_pop;
    logic [7:0]         tx_rdata;
    logic [FIFO_AW:0]   tx_count;
    logic               tx_full;
    logic               tx_empty;

    logic               rx_push;
    logic               rx_pop;
    logic [7:0]         rx_rdata;
    logic [FIFO_AW:0]   rx_count;
    logic               rx_full;
    logic               rx_empty;

    assign tx_full  = tx_count[FIFO_AW];
    assign tx_empty = (tx_count == '0);
    assign rx_full  = rx_count[FIFO_AW];
    assign rx_empty = (rx_count == '0);

    // IO handshake
    typedef enum logic [1:0] {
        IO_IDLE,
`ifdef BF_UART_CRLF_EN
        IO_LF,
`endif
        IO_ACK
    } io_state_t;

    io_state_t  io_state_q;
    io_state_t  io_state_d;
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            io_state_q <= IO_IDLE;
            rdata_q    <= 8'h00;
        end else begin
            io_state_q <= io_state_d;
            if (rx_pop) rdata_q <= rx_rdata;
        end
    end

    always_comb begin
        io_state_d = io_state_q;
        tx_push    = 1'b0;
        tx_wdata   = io.io_wdata;
        rx_pop     = 1'b0;
        unique case (io_state_q)
            IO_IDLE: begin
                if (io.io_req) begin
                    if (io.io_dir == `DIRECTION_WRITE) begin
`ifdef BF_UART_CRLF_EN
                        if (io.io_wdata == 8'h0A) begin
                            // Both bytes of CR LF must fit up front.
                            if (tx_count <= TWO_FREE) begin
                                tx_push    = 1'b1;
                                tx_wdata   = 8'h0D;
                                io_state_d = IO_LF;
                            end
                        end else if (!tx_full) begin
                            tx_push    = 1'b1;
                            io_state_d = IO_ACK;
                        end
`else
                        if (!tx_full) begin
                            tx_push    = 1'b1;
                            io_state_d = IO_ACK;
                        end
`endif
                    end else if (!rx_empty) begin
                        rx_pop     = 1'b1;
                        io_state_d = IO_ACK;
                    end
                end
            end
`ifdef BF_UART_CRLF_EN
            IO_LF: begin
                tx_push    = 1'b1;
                tx_wdata   = 8'h0A;
                io_state_d = IO_ACK;
            end
`endif
            IO_ACK: begin
                // io_req is still high here; it is deliberately ignored.
                io_state_d = IO_IDLE;
            end
            default: io_state_d = IO_IDLE;
        endcase
    end

    assign io.io_ack   = (io_state_q == IO_ACK);
    assign io.io_rdata = rdata_q;

    // TX shifter
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t     tx_state_q;
    tx_state_t     tx_state_d;
    logic [CW-1:0] tx_cnt_q;
    logic [CW-1:0] tx_cnt_d;
    logic [2:0]    tx_bit_q;
    logic [2:0]    tx_bit_d;
    logic [7:0]    tx_sh_q;
    logic [7:0]    tx_sh_d;
    logic          tx_line_q;
    logic          tx_line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_rdata;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_MAX) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_MAX) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_MAX) begin
                    tx_cnt_d = '0;
                    // Chain frames with no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_d    = tx_rdata;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level follows the next state so uart_tx is a flop.
        tx_line_d = 1'b1;
        if (tx_state_d == TX_START) begin
            tx_line_d = 1'b0;
        end else if (tx_state_d == TX_DATA) begin
            tx_line_d = tx_sh_d[0];
        end
    end

    assign uart_tx = tx_line_q;

    // RX sampler
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    logic          rx_meta;
    logic          rx_s;
    rx_state_t     rx_state_q;
    rx_state_t     rx_state_d;
    logic [CW-1:0] rx_cnt_q;
    logic [CW-1:0] rx_cnt_d;
    logic [2:0]    rx_bit_q;
    logic [2:0]    rx_bit_d;
    logic [7:0]    rx_sh_q;
    logic [7:0]    rx_sh_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_meta    <= uart_rx;
            rx_s       <= rx_meta;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid-start re-check rejects short glitches.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_MAX) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_MAX) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        // Overflow drops the byte silently.
                        rx_push    = !rx_full;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_BREAK: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    bf_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .count (tx_count)
    );

    bf_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_sh_q),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .count (rx_count)
    );
endmodule

// File: tb/tb_bf_uart_io.sv
// tb_bf_uart_io: random-stimulus bench for bf_uart_io with a UART line
// decoder/encoder and byte-queue reference model.
`timescale 1ns/1ps
module tb_bf_uart_io;
    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic DIR_WR = 1'b1;
`ifdef BF_UART_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b1;
    bit prev_ack = 1'b0;
    int tx_got[$];
    int tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [63:0] wv;

    bf_uart_io_if io ();

    bf_uart_io #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (io),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int need(input logic [7:0] b);
        return (CRLF && b == 8'h0A) ? 2 : 1;
    endfunction

    function automatic void exp_tx(input logic [7:0] b);
        if (CRLF && b == 8'h0A) tx_exp.push_back(8'h0D);
        tx_exp.push_back(int'(b));
    endfunction

    // ack must be a single-cycle pulse
    always @(negedge clk) begin
        if (prev_ack) chk("ack_pulse", io.io_ack, 0);
        prev_ack = (io.io_ack === 1'b1);
    end

    // UART line decoder: samples mid-bit, pushes byte (+256 on bad stop)
    initial begin
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && uart_tx === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        mb[i] = uart_tx;
                    end
                    repeat (CPB) @(negedge clk);
                    tx_got.push_back(uart_tx === 1'b1 ?
                                     int'(mb) : 256 + int'(mb));
                end
            end
        end
    end

    task automatic io_write(input logic [7:0] b, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        io.io_req = 1'b1;
        io.io_dir = DIR_WR;
        io.io_wdata = b;
        while (!got && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (io.io_ack === 1'b1) got = 1'b1;
        end
        io.io_req = 1'b0;
        chk("wr_ack", got, 1);
    endtask

    task automatic io_read(output logic [7:0] d, output bit got,
                           input int bound);
        int w;
        w = 0;
        got = 1'b0;
        d = 8'h00;
        @(negedge clk);
        io.io_req = 1'b1;
        io.io_dir = ~DIR_WR;
        while (!got && w < bound) begin
            @(negedge clk);
            w++;
            if (io.io_ack === 1'b1) begin
                got = 1'b1;
                d = io.io_rdata;
            end
        end
        io.io_req = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic rx_check_all();
        logic [7:0] d;
        bit got;
        while (rx_exp.size() > 0) begin
            io_read(d, got, 200);
            chk("rd_ack", got, 1);
            chk("rd_data", d, rx_exp.pop_front());
        end
        io_read(d, got, 50);
        chk("rd_empty_block", got, 0);
    endtask

    task automatic tx_drain(input string tag);
        int w;
        int n;
        w = 0;
        while (tx_got.size() < tx_exp.size() && w < 4000) begin
            @(negedge clk);
            w++;
        end
        repeat (12*CPB) @(negedge clk);
        chk({tag, "_count"}, tx_got.size(), tx_exp.size());
        n = (tx_got.size() < tx_exp.size()) ? tx_got.size() : tx_exp.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, tx_got[i], tx_exp[i]);
        tx_got.delete();
        tx_exp.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int occ;
        int f;
        int w;
        bit blocked;
        bit got;
        bit allhi;
        logic [7:0] d;
        logic [7:0] b;
        logic [9:0] fr;
        logic [39:0] ew;
        logic [63:0] sh;

        io.io_req = 1'b0;
        io.io_dir = 1'b0;
        io.io_wdata = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", io.io_ack, 0);
        chk("rst_rdata", io.io_rdata, 8'h00);
        chk("rst_tx", uart_tx, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write 0x41: latency and exact waveform
        wv = '1;
        fork
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                wv[i] = uart_tx;
            end
        join_none
        io_write(8'h41, lat);
        chk("lat_41", lat, 1);
        exp_tx(8'h41);
        repeat (70) @(negedge clk);
        f = 0;
        while (f < 20 && wv[f] !== 1'b0) f++;
        chk("wave_start_found", f < 20, 1);
        fr = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 40; i++) ew[i] = fr[i/CPB];
        sh = wv >> f;
        chk("wave_41", sh[39:0], ew);
        allhi = 1'b1;
        for (int i = f + 40; i < 64; i++) if (wv[i] !== 1'b1) allhi = 1'b0;
        chk("wave_idle_after", allhi, 1);
        tx_drain("tx41");

        // TX FIFO full: line busy, then 17 writes
        io_write(8'hA5, lat);
        exp_tx(8'hA5);
        repeat (2) @(negedge clk);
        occ = 0;
        blocked = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            io_write(b, lat);
            exp_tx(b);
            if (!blocked && occ + need(b) <= DEPTH) begin
                chk("burst_lat", lat, need(b));
                occ += need(b);
            end else if (!blocked) begin
                blocked = 1'b1;
                chk("burst_full_stall", lat > need(b), 1);
            end
        end
        tx_drain("burst");

        // read blocks on empty RX, completes after a frame arrives
        io_read(d, got, 100);
        chk("rd_block_100", got, 0);
        fork
            send_frame(8'h5A, 1'b1);
        join_none
        io_read(d, got, 200);
        chk("rd_5a_ack", got, 1);
        chk("rd_5a_data", d, 8'h5A);
        repeat (10) @(negedge clk);
        chk("rdata_held", io.io_rdata, 8'h5A);

        // framing error frame is dropped
        send_frame(8'hC3, 1'b0);
        repeat (CPB) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        rx_exp.push_back(8'h7E);
        rx_check_all();

        // random mix of writes and (possibly bad) RX frames
        for (int it = 0; it < 14; it++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                io_write(b, lat);
                exp_tx(b);
            end else begin
                got = ($urandom_range(0, 3) != 0);
                send_frame(b, got);
                if (got) rx_exp.push_back(b);
                if ($urandom_range(0, 1) == 1) rx_check_all();
            end
        end
        rx_check_all();
        tx_drain("rand");

        // RX FIFO overflow: 17th byte dropped
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
        end
        rx_check_all();

        // reset mid-frame
        send_frame(8'h33, 1'b1);
        mon_en = 1'b0;
        io_write(8'hFF, lat);
        io_write(8'h12, lat);
        w = 0;
        while (uart_tx !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_frame_started", uart_tx, 0);
        repeat (3*CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", uart_tx, 1);
        chk("midrst_ack", io.io_ack, 0);
        chk("midrst_rdata", io.io_rdata, 8'h00);
        rst = 1'b0;
        tx_got.delete();
        mon_en = 1'b1;
        io_read(d, got, 60);
        chk("midrst_rx_empty", got, 0);
        repeat (15*CPB) @(negedge clk);
        chk("midrst_tx_flushed", tx_got.size(), 0);
        tx_got.delete();

        // line feed handling
        io_write(8'h0A, lat);
        chk("lat_0a", lat, need(8'h0A));
        exp_tx(8'h0A);
        tx_drain("lf");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
